// File: rtl/wb_ntp_clock.sv
// wb_ntp_clock: Wishbone-attached NTP-format (32.32 seconds.fraction) wall
// clock with a programmable per-cycle increment, an atomic 64-bit read path
// through a seconds shadow register, and N_CAP event capture channels.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wb_*           Wishbone slave (byte address, word index = adr[5:2])
//   o_wb_ack         registered single-cycle acknowledge
//   o_wb_rdt         registered read data, held until the next read
//   i_cap            asynchronous rising-edge capture inputs
//   o_irq            level interrupt, IRQ_EN & |VALID
module wb_ntp_clock #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned SUB_W       = 16,
  parameter logic [31:0] INC_DEFAULT = 32'h0055E63C,
  parameter int unsigned N_CAP       = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_rdt,
  input  logic [N_CAP-1:0] i_cap,
  output logic             o_irq
);

  localparam int unsigned ACC_W = 64 + SUB_W;

  localparam logic [3:0] W_TIME_LO = 4'd0;
  localparam logic [3:0] W_TIME_HI = 4'd1;
  localparam logic [3:0] W_INC     = 4'd2;
  localparam logic [3:0] W_CTRL    = 4'd3;

  logic [ACC_W-1:0] acc;
  logic [31:0]      shadow;
  logic [31:0]      stg_lo;
  logic [31:0]      stg_hi;
  logic [31:0]      inc;
  logic             run;
  logic             irq_en;
  logic [N_CAP-1:0] valid;
  logic [N_CAP-1:0] ovr;
  logic [N_CAP-1:0] sync1;
  logic [N_CAP-1:0] sync2;
  logic [N_CAP-1:0] sync3;
  logic [63:0]      cap [N_CAP];

  // CLK_HZ only documents where INC_DEFAULT comes from; byte offset bits are don't-care
  logic unused_bits;
  assign unused_bits = ^{32'(CLK_HZ), i_wb_adr[1:0]};

  // Byte-lane merge of write data into an existing register value
  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
    end
    return r;
  endfunction

  // Bus decode: side effects fire only on the ack-setting edge
  logic [3:0]       word_c;
  logic             access_c;
  logic             wr_c;
  logic             rd_c;
  logic             ctrl_wr_c;
  logic             commit_c;
  logic [31:0]      stg_hi_merged_c;

  assign word_c          = i_wb_adr[5:2];
  assign access_c        = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr_c            = access_c & i_wb_we;
  assign rd_c            = access_c & ~i_wb_we;
  assign ctrl_wr_c       = wr_c && (word_c == W_CTRL);
  assign commit_c        = wr_c && (word_c == W_TIME_HI);
  assign stg_hi_merged_c = merge_lanes(stg_hi, i_wb_dat, i_wb_sel);

  // Capture/status next state; W1C is applied before the new edge is judged
  logic [N_CAP-1:0] rise_c;
  logic [N_CAP-1:0] clr_valid_c;
  logic [N_CAP-1:0] clr_ovr_c;
  logic [N_CAP-1:0] valid_keep_c;
  logic [N_CAP-1:0] load_c;
  logic [N_CAP-1:0] valid_next_c;
  logic [N_CAP-1:0] ovr_next_c;
  logic             irq_en_next_c;

  assign rise_c        = sync2 & ~sync3;
  assign clr_valid_c   = (ctrl_wr_c && i_wb_sel[1]) ? i_wb_dat[8 +: N_CAP]  : '0;
  assign clr_ovr_c     = (ctrl_wr_c && i_wb_sel[2]) ? i_wb_dat[16 +: N_CAP] : '0;
  assign valid_keep_c  = valid & ~clr_valid_c;
  assign load_c        = rise_c & ~valid_keep_c;
  assign valid_next_c  = valid_keep_c | rise_c;
  assign ovr_next_c    = (ovr & ~clr_ovr_c) | (rise_c & valid_keep_c);
  assign irq_en_next_c = (ctrl_wr_c && i_wb_sel[0]) ? i_wb_dat[1] : irq_en;

  // Read mux from pre-edge state
  logic [31:0] rdata_c;
  always_comb begin
    rdata_c = '0;
    case (word_c)
      W_TIME_LO: rdata_c = acc[SUB_W +: 32];
      W_TIME_HI: rdata_c = shadow;
      W_INC:     rdata_c = inc;
      W_CTRL: begin
        rdata_c[0]            = run;
        rdata_c[1]            = irq_en;
        rdata_c[8 +: N_CAP]   = valid;
        rdata_c[16 +: N_CAP]  = ovr;
      end
      default: begin
        for (int k = 0; k < int'(N_CAP); k++) begin
          if (word_c == 4'(4 + 2*k)) rdata_c = cap[k][31:0];
          if (word_c == 4'(5 + 2*k)) rdata_c = cap[k][63:32];
        end
      end
    endcase
  end

  // Bus registers, time accumulator and interrupt
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      shadow   <= '0;
      stg_lo   <= '0;
      stg_hi   <= '0;
      inc      <= INC_DEFAULT;
      run      <= 1'b1;
      irq_en   <= 1'b0;
      o_irq    <= 1'b0;
      acc      <= '0;
    end else begin
      o_wb_ack <= access_c;
      if (rd_c) o_wb_rdt <= rdata_c;
      // SEC is frozen by the TIME_LO read so TIME_HI completes an atomic pair
      if (rd_c && word_c == W_TIME_LO) shadow <= acc[ACC_W-1 -: 32];
      if (wr_c) begin
        case (word_c)
          W_TIME_LO: stg_lo <= merge_lanes(stg_lo, i_wb_dat, i_wb_sel);
          W_TIME_HI: stg_hi <= stg_hi_merged_c;
          W_INC:     inc    <= merge_lanes(inc, i_wb_dat, i_wb_sel);
          W_CTRL:    if (i_wb_sel[0]) run <= i_wb_dat[0];
          default:   ;
        endcase
      end
      irq_en <= irq_en_next_c;
      o_irq  <= irq_en_next_c & (|valid_next_c);
      // Commit overrides the increment so the written time is exact
      if (commit_c) begin
        acc <= {stg_hi_merged_c, stg_lo, SUB_W'(0)};
      end else if (run) begin
        acc <= acc + ACC_W'(inc);
      end
    end
  end

  // Capture channels: 2-FF synchronizer, edge-detect flop, capture registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      valid <= '0;
      ovr   <= '0;
      for (int k = 0; k < int'(N_CAP); k++) cap[k] <= '0;
    end else begin
      sync1 <= i_cap;
      sync2 <= sync1;
      sync3 <= sync2;
      valid <= valid_next_c;
      ovr   <= ovr_next_c;
      for (int k = 0; k < int'(N_CAP); k++) begin
        if (load_c[k]) cap[k] <= acc[SUB_W +: 64];
      end
    end
  end

endmodule

// File: tb/tb_wb_ntp_clock.sv
// tb_wb_ntp_clock: directed and randomized bench for wb_ntp_clock, checked
// every cycle against a transaction-level model of the time counter.
module tb_wb_ntp_clock;

  localparam int unsigned N_CAP       = 2;
  localparam int unsigned SUB_W       = 16;
  localparam logic [31:0] INC_DEFAULT = 32'h0055E63C;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic [5:0]       adr    = '0;
  logic [31:0]      dat    = '0;
  logic [3:0]       sel    = '0;
  logic             we     = 1'b0;
  logic             cyc    = 1'b0;
  logic             stb    = 1'b0;
  logic [N_CAP-1:0] cap_in = '0;
  logic             ack;
  logic [31:0]      rdt;
  logic             irq;

  always #5 clk = ~clk;

  wb_ntp_clock #(
    .CLK_HZ(50000000), .SUB_W(SUB_W), .INC_DEFAULT(INC_DEFAULT), .N_CAP(N_CAP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel), .i_wb_we(we),
    .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_ack(ack), .o_wb_rdt(rdt),
    .i_cap(cap_in), .o_irq(irq)
  );

  // ---------------- reference model ----------------
  logic [79:0]      m_acc;          // {SEC, FRAC, sub-fraction}
  logic [31:0]      m_shadow, m_stg_lo, m_stg_hi, m_inc;
  logic             m_run, m_irq_en;
  logic [N_CAP-1:0] m_valid, m_ovr;
  logic [63:0]      m_cap [N_CAP];
  logic [N_CAP-1:0] m_hist [3];     // cap input as sampled 1,2,3 edges ago
  logic             exp_ack, exp_irq;
  logic [31:0]      exp_rdt;

  // Inputs as seen by the DUT at the last rising edge
  logic             s_live = 1'b0;
  logic             s_cyc, s_stb, s_we;
  logic [5:0]       s_adr;
  logic [31:0]      s_dat;
  logic [3:0]       s_sel;
  logic [N_CAP-1:0] s_cap;

  always @(posedge clk) begin
    s_live <= rst_n;
    s_cyc  <= cyc;
    s_stb  <= stb;
    s_we   <= we;
    s_adr  <= adr;
    s_dat  <= dat;
    s_sel  <= sel;
    s_cap  <= cap_in;
  end

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int w);
    logic [31:0] r;
    r = '0;
    if (w == 0)      r = m_acc[47:16];
    else if (w == 1) r = m_shadow;
    else if (w == 2) r = m_inc;
    else if (w == 3) begin
      r[0] = m_run;
      r[1] = m_irq_en;
      r[8 +: N_CAP]  = m_valid;
      r[16 +: N_CAP] = m_ovr;
    end else if (w < 4 + 2*int'(N_CAP)) begin
      r = (w % 2 == 1) ? m_cap[(w-4)/2][63:32] : m_cap[(w-4)/2][31:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_acc = '0; m_shadow = '0; m_stg_lo = '0; m_stg_hi = '0; m_inc = INC_DEFAULT;
    m_run = 1'b1; m_irq_en = 1'b0; m_valid = '0; m_ovr = '0;
    for (int k = 0; k < int'(N_CAP); k++) m_cap[k] = '0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    exp_ack = 1'b0; exp_irq = 1'b0; exp_rdt = '0;
  endtask

  // One rising edge worth of behaviour, from the inputs sampled at that edge
  task automatic model_step();
    logic             go, commit;
    int               w;
    logic [79:0]      acc_pre;
    logic [31:0]      inc_pre, hi_new;
    logic             run_pre;
    logic [N_CAP-1:0] ev, clr_v, clr_o;
    go      = s_cyc & s_stb & ~exp_ack;
    w       = int'(s_adr[5:2]);
    acc_pre = m_acc;
    inc_pre = m_inc;
    run_pre = m_run;
    commit  = 1'b0;
    hi_new  = '0;
    ev      = m_hist[1] & ~m_hist[2];
    clr_v   = '0;
    clr_o   = '0;
    if (go && !s_we) begin
      exp_rdt = model_read(w);
      if (w == 0) m_shadow = acc_pre[79:48];
    end
    if (go && s_we) begin
      case (w)
        0: m_stg_lo = lanes(m_stg_lo, s_dat, s_sel);
        1: begin m_stg_hi = lanes(m_stg_hi, s_dat, s_sel); hi_new = m_stg_hi; commit = 1'b1; end
        2: m_inc = lanes(m_inc, s_dat, s_sel);
        3: begin
          if (s_sel[0]) begin m_run = s_dat[0]; m_irq_en = s_dat[1]; end
          if (s_sel[1]) clr_v = s_dat[8 +: N_CAP];
          if (s_sel[2]) clr_o = s_dat[16 +: N_CAP];
        end
        default: ;
      endcase
    end
    m_valid = m_valid & ~clr_v;
    m_ovr   = m_ovr & ~clr_o;
    for (int k = 0; k < int'(N_CAP); k++) begin
      if (ev[k]) begin
        if (!m_valid[k]) begin m_cap[k] = acc_pre[79:16]; m_valid[k] = 1'b1; end
        else m_ovr[k] = 1'b1;
      end
    end
    if (commit)       m_acc = {hi_new, m_stg_lo, 16'h0};
    else if (run_pre) m_acc = acc_pre + 80'(inc_pre);
    exp_irq = m_irq_en & (|m_valid);
    exp_ack = go;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = s_cap;
  endtask

  // ---------------- comparison bookkeeping ----------------
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;

  lit_t lit_arr [64];
  int   lit_wr = 0;
  int   lit_rd = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: step model, check outputs, then hand-computed literals
  always @(negedge clk) begin
    if (!rst_n || !s_live) model_reset();
    else model_step();
    check("ack", 32'(ack), 32'(exp_ack));
    check("irq", 32'(irq), 32'(exp_irq));
    check("rdt", rdt, exp_rdt);
    while (lit_rd < lit_wr) begin
      check(lit_arr[lit_rd].name, lit_arr[lit_rd].act, lit_arr[lit_rd].exp);
      lit_rd++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_arr[lit_wr].name = nm;
    lit_arr[lit_wr].act  = act;
    lit_arr[lit_wr].exp  = exp;
    lit_wr++;
  endtask

  task automatic wb_xfer(input logic [5:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    @(posedge clk); #1;
    adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    r = rdt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] unused_r;
    wb_xfer(a, 1'b1, d, 4'hF, unused_r);
  endtask

  task automatic wb_read(input logic [5:0] a, output logic [31:0] r);
    wb_xfer(a, 1'b0, 32'h0, 4'h0, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse(input int k);
    @(posedge clk); #1 cap_in[k] = 1'b1;
    repeat (3) @(posedge clk);
    #1 cap_in[k] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  logic stop = 1'b0;

  initial begin
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    wb_read(6'h0C, r); lit("ctrl_reset", r, 32'h0000_0001);
    wb_read(6'h08, r); lit("inc_reset", r, 32'h0055_E63C);
    lit("irq_reset", 32'(irq), 32'h0);

    // commit then advance across the fraction carry
    wb_write(6'h08, 32'h0001_0000);
    wb_write(6'h00, 32'hFFFF_FFFE);
    wb_write(6'h04, 32'h0000_0005);
    idle(1);
    wb_read(6'h00, r); lit("carry_frac", r, 32'h0000_0000);
    wb_read(6'h04, r); lit("carry_sec", r, 32'h0000_0006);

    // era rollover, no stall
    wb_write(6'h00, 32'hFFFF_FFFF);
    wb_write(6'h04, 32'hFFFF_FFFF);
    wb_read(6'h00, r); lit("wrap_frac", r, 32'h0000_0000);
    wb_read(6'h04, r); lit("wrap_sec", r, 32'h0000_0000);

    // shadow holds SEC from the TIME_LO read
    wb_write(6'h00, 32'hFFFF_FFF0);
    wb_write(6'h04, 32'h0000_0007);
    wb_read(6'h00, r); lit("shadow_lo", r, 32'hFFFF_FFF1);
    idle(20);
    wb_read(6'h04, r); lit("shadow_hi_old", r, 32'h0000_0007);
    wb_read(6'h00, r);
    wb_read(6'h04, r); lit("shadow_hi_new", r, 32'h0000_0008);

    // capture, overrun, W1C
    wb_write(6'h0C, 32'h0000_0003);
    wb_write(6'h00, 32'h0000_0000);
    wb_write(6'h04, 32'h0000_0010);
    pulse(0);
    wb_read(6'h10, r); lit("cap0_lo", r, 32'h0000_0003);
    wb_read(6'h14, r); lit("cap0_hi", r, 32'h0000_0010);
    wb_read(6'h0C, r); lit("ctrl_valid", r, 32'h0000_0103);
    lit("irq_set", 32'(irq), 32'h1);
    pulse(0);
    wb_read(6'h10, r); lit("cap0_kept", r, 32'h0000_0003);
    wb_read(6'h0C, r); lit("ctrl_ovr", r, 32'h0001_0103);
    wb_write(6'h0C, 32'h0001_0100);
    wb_read(6'h0C, r); lit("ctrl_cleared", r, 32'h0000_0000);
    lit("irq_cleared", 32'(irq), 32'h0);
    wb_write(6'h0C, 32'h0000_0003);

    // randomized bus traffic against free-running capture inputs
    fork
      begin
        logic [3:0]  w4;
        logic [1:0]  lo2;
        logic [31:0] d;
        logic [3:0]  s;
        int unsigned op;
        for (int i = 0; i < 400; i++) begin
          op  = $urandom_range(0, 9);
          w4  = 4'($urandom_range(0, 15));
          lo2 = 2'($urandom_range(0, 3));
          d   = $urandom;
          s   = 4'($urandom_range(0, 15));
          if (op <= 3) begin
            wb_xfer({w4, lo2}, 1'b0, d, s, r);
          end else if (op <= 5) begin
            wb_xfer({w4, lo2}, 1'b1, d, s, r);
          end else if (op == 6) begin
            d[0] = ($urandom_range(0, 7) != 0);
            wb_xfer(6'h0C, 1'b1, d, s, r);
          end else if (op == 7) begin
            wb_write(6'h00, $urandom);
            wb_write(6'h04, $urandom);
          end else if (op == 8) begin
            wb_write(6'h08, 32'($urandom_range(0, 32'h00FF_FFFF)));
          end else begin
            idle(int'($urandom_range(0, 3)));
          end
        end
        stop = 1'b1;
      end
      begin
        int cnt [N_CAP];
        for (int k = 0; k < int'(N_CAP); k++) cnt[k] = 0;
        while (!stop) begin
          @(posedge clk); #1;
          for (int k = 0; k < int'(N_CAP); k++) begin
            if (cnt[k] >= 2 && $urandom_range(0, 3) == 0) begin
              cap_in[k] = ~cap_in[k];
              cnt[k] = 0;
            end else begin
              cnt[k]++;
            end
          end
        end
      end
    join
    @(posedge clk); #1 cap_in = '0;
    idle(4);

    // reset in the middle of a write cycle
    @(posedge clk); #1;
    adr = 6'h08; dat = 32'h1234_5678; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 lit("ack_in_reset", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst_n = 1'b1;
    wb_read(6'h0C, r); lit("ctrl_after_rst", r, 32'h0000_0001);
    wb_read(6'h08, r); lit("inc_after_rst", r, 32'h0055_E63C);
    wb_read(6'h04, r); lit("shadow_after_rst", r, 32'h0000_0000);
    wb_read(6'h10, r); lit("cap0_after_rst", r, 32'h0000_0000);
    wb_read(6'h1C, r); lit("cap1_after_rst", r, 32'h0000_0000);
    lit("irq_after_rst", 32'(irq), 32'h0);

    idle(2);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
